// File: rtl/bus_err_injector.sv
// Response-path error injector: tags requests by address window and forces cfg_code_i onto their responses.
// Optional beat statistics counter enabled by defining BUS_ERR_INJ_STATS_EN.
module bus_err_injector #(
  parameter int AddrWidth      = 48,
  parameter int ErrBits        = 3,
  parameter int NumOutstanding = 4,
  parameter int NumChannels    = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumChannels-1:0] req_hs_valid_i,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [NumChannels-1:0] rsp_hs_valid_i,
  input  logic [NumChannels-1:0] rsp_burst_last_i,
  input  logic [ErrBits-1:0]     rsp_err_i,
  output logic [ErrBits-1:0]     rsp_err_o,
  input  logic                   cfg_en_i,
  input  logic                   cfg_arm_i,
  input  logic [AddrWidth-1:0]   cfg_base_i,
  input  logic [AddrWidth-1:0]   cfg_mask_i,
  input  logic [ErrBits-1:0]     cfg_code_i,
  input  logic [15:0]            cfg_count_i,
  output logic                   inj_armed_o,
  output logic                   inj_done_o,
  output logic [15:0]            inj_remaining_o,
  output logic [NumChannels-1:0] tag_overflow_o,
  output logic [31:0]            inj_beats_o
);

  localparam int PtrW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
  localparam int CntW = $clog2(NumOutstanding + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] remaining_q, remaining_d;
  logic        unlimited_q, unlimited_d;

  logic                   addr_match;
  logic                   tag_flag;
  logic                   tagged_push;
  logic [NumChannels-1:0] push_vec;
  logic [NumChannels-1:0] hit_vec;
  logic [NumChannels-1:0] ovf_vec;

  assign addr_match = ((req_addr_i ^ cfg_base_i) & cfg_mask_i) == '0;
  // Arm pulse wins over a simultaneous request: that request is pushed untagged.
  assign tag_flag   = (state_q == ST_ARMED) & cfg_en_i & addr_match & ~cfg_arm_i;

  // Per-channel tag FIFO; an overflowed channel is frozen in pass-through until reset.
  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    logic [NumOutstanding-1:0] mem_q;
    logic [PtrW-1:0]           wr_ptr_q;
    logic [PtrW-1:0]           rd_ptr_q;
    logic [CntW-1:0]           cnt_q;
    logic                      ovf_q;
    logic                      full;
    logic                      empty;
    logic                      push;
    logic                      pop;
    logic                      head_flag;

    assign full      = (cnt_q == CntW'(NumOutstanding));
    assign empty     = (cnt_q == '0);
    assign push      = req_hs_valid_i[c] & ~ovf_q & ~full;
    assign pop       = rsp_hs_valid_i[c] & rsp_burst_last_i[c] & ~ovf_q & ~empty;
    assign head_flag = mem_q[rd_ptr_q];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        ovf_q    <= 1'b0;
      end else begin
        if (req_hs_valid_i[c] && full) begin
          ovf_q <= 1'b1;
        end
        if (push) begin
          wr_ptr_q <= (wr_ptr_q == PtrW'(NumOutstanding - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
          rd_ptr_q <= (rd_ptr_q == PtrW'(NumOutstanding - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
          cnt_q <= cnt_q + CntW'(1);
        end else if (pop && !push) begin
          cnt_q <= cnt_q - CntW'(1);
        end
      end
    end

    // NOTE: flag storage is not reset; the reset pointers and count make stale entries unreachable.
    always_ff @(posedge clk_i) begin
      if (push) begin
        mem_q[wr_ptr_q] <= tag_flag;
      end
    end

    assign push_vec[c] = push;
    assign ovf_vec[c]  = ovf_q;
    assign hit_vec[c]  = rsp_hs_valid_i[c] & ~ovf_q & ~empty & head_flag;
  end : g_chan

  assign tagged_push = (|push_vec) & tag_flag;
  assign rsp_err_o   = (|hit_vec) ? cfg_code_i : rsp_err_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      unlimited_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      unlimited_q <= unlimited_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    unlimited_d = unlimited_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_arm_i && cfg_en_i) begin
          state_d     = ST_ARMED;
          remaining_d = cfg_count_i;
          unlimited_d = (cfg_count_i == '0);
        end
      end
      ST_ARMED: begin
        if (!cfg_en_i) begin
          state_d = ST_IDLE;
        end else if (cfg_arm_i) begin
          remaining_d = cfg_count_i;
          unlimited_d = (cfg_count_i == '0);
        end else if (tagged_push && !unlimited_q) begin
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (!cfg_en_i) begin
          state_d = ST_IDLE;
        end else if (cfg_arm_i) begin
          state_d     = ST_ARMED;
          remaining_d = cfg_count_i;
          unlimited_d = (cfg_count_i == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign inj_armed_o     = (state_q == ST_ARMED);
  assign inj_done_o      = (state_q == ST_DONE);
  assign inj_remaining_o = remaining_q;
  assign tag_overflow_o  = ovf_vec;

`ifdef BUS_ERR_INJ_STATS_EN
  logic [31:0] beats_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beats_q <= '0;
    end else if ((|hit_vec) && (beats_q != 32'hFFFF_FFFF)) begin
      beats_q <= beats_q + 32'd1;
    end
  end

  assign inj_beats_o = beats_q;
`else
  assign inj_beats_o = '0;
`endif

`ifndef SYNTHESIS
  a_req_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(req_hs_valid_i));
  a_rsp_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(rsp_hs_valid_i));
  a_code_nonzero: assert property (@(posedge clk_i) disable iff (rst_i)
                                   (state_q == ST_ARMED) |-> (cfg_code_i != '0));
`endif

endmodule

// File: tb/tb_bus_err_injector.sv
// Directed, table-driven bench for bus_err_injector (single channel, 4-deep tag FIFO).
module tb_bus_err_injector;

  localparam int AW = 48;
  localparam int EB = 3;
  localparam int NC = 1;

`ifdef BUS_ERR_INJ_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [NC-1:0] req_hs_valid_i;
  logic [AW-1:0] req_addr_i;
  logic [NC-1:0] rsp_hs_valid_i;
  logic [NC-1:0] rsp_burst_last_i;
  logic [EB-1:0] rsp_err_i;
  logic [EB-1:0] rsp_err_o;
  logic          cfg_en_i;
  logic          cfg_arm_i;
  logic [AW-1:0] cfg_base_i;
  logic [AW-1:0] cfg_mask_i;
  logic [EB-1:0] cfg_code_i;
  logic [15:0]   cfg_count_i;
  logic          inj_armed_o;
  logic          inj_done_o;
  logic [15:0]   inj_remaining_o;
  logic [NC-1:0] tag_overflow_o;
  logic [31:0]   inj_beats_o;

  bus_err_injector #(
    .AddrWidth(AW), .ErrBits(EB), .NumOutstanding(4), .NumChannels(NC)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_hs_valid_i(req_hs_valid_i), .req_addr_i(req_addr_i),
    .rsp_hs_valid_i(rsp_hs_valid_i), .rsp_burst_last_i(rsp_burst_last_i),
    .rsp_err_i(rsp_err_i), .rsp_err_o(rsp_err_o),
    .cfg_en_i(cfg_en_i), .cfg_arm_i(cfg_arm_i),
    .cfg_base_i(cfg_base_i), .cfg_mask_i(cfg_mask_i),
    .cfg_code_i(cfg_code_i), .cfg_count_i(cfg_count_i),
    .inj_armed_o(inj_armed_o), .inj_done_o(inj_done_o),
    .inj_remaining_o(inj_remaining_o), .tag_overflow_o(tag_overflow_o),
    .inj_beats_o(inj_beats_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [EB-1:0] exp_err;
    logic [15:0]   exp_rem;
    logic          exp_done;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i            = 1'b1;
    req_hs_valid_i   = '0;
    req_addr_i       = '0;
    rsp_hs_valid_i   = '0;
    rsp_burst_last_i = '0;
    rsp_err_i        = '0;
    cfg_en_i         = 1'b0;
    cfg_arm_i        = 1'b0;
    cfg_count_i      = '0;
    #1;
    check("rst_armed", 48'(inj_armed_o), 48'd0);
    check("rst_done", 48'(inj_done_o), 48'd0);
    check("rst_remaining", 48'(inj_remaining_o), 48'd0);
    check("rst_overflow", 48'(tag_overflow_o), 48'd0);
    check("rst_beats", 48'(inj_beats_o), 48'd0);
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic arm(input logic [15:0] count);
    cfg_count_i = count;
    cfg_arm_i   = 1'b1;
    step();
    cfg_arm_i   = 1'b0;
  endtask

  task automatic req(input logic [AW-1:0] addr, input logic with_arm);
    req_hs_valid_i = 1'b1;
    req_addr_i     = addr;
    cfg_arm_i      = with_arm;
    step();
    req_hs_valid_i = 1'b0;
    cfg_arm_i      = 1'b0;
  endtask

  task automatic rsp(input string name, input logic [EB-1:0] err, input logic last,
                     input logic [EB-1:0] exp);
    rsp_hs_valid_i   = 1'b1;
    rsp_burst_last_i = last;
    rsp_err_i        = err;
    #1;
    check(name, 48'(rsp_err_o), 48'(exp));
    step();
    rsp_hs_valid_i   = 1'b0;
    rsp_burst_last_i = 1'b0;
    rsp_err_i        = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cfg_base_i = 48'h1000;
    cfg_mask_i = 48'hFFFF_F000;
    cfg_code_i = 3'd4;
    do_reset();

    // Window match with a budget of two.
    vecs[0] = '{addr: 48'h1004, exp_err: 3'd4, exp_rem: 16'd1, exp_done: 1'b0};
    vecs[1] = '{addr: 48'h2000, exp_err: 3'd0, exp_rem: 16'd1, exp_done: 1'b0};
    vecs[2] = '{addr: 48'h1008, exp_err: 3'd4, exp_rem: 16'd0, exp_done: 1'b1};
    vecs[3] = '{addr: 48'h1010, exp_err: 3'd0, exp_rem: 16'd0, exp_done: 1'b1};
    cfg_en_i = 1'b1;
    arm(16'd2);
    check("t1_armed", 48'(inj_armed_o), 48'd1);
    check("t1_rem_loaded", 48'(inj_remaining_o), 48'd2);
    for (int i = 0; i < 4; i++) begin
      req(vecs[i].addr, 1'b0);
      check($sformatf("t1_rem_%0d", i), 48'(inj_remaining_o), 48'(vecs[i].exp_rem));
      check($sformatf("t1_done_%0d", i), 48'(inj_done_o), 48'(vecs[i].exp_done));
      rsp($sformatf("t1_err_%0d", i), 3'd0, 1'b1, vecs[i].exp_err);
    end

    // Tagged four-beat burst, then untagged and empty-FIFO pass-through.
    do_reset();
    cfg_code_i = 3'd3;
    cfg_en_i   = 1'b1;
    arm(16'd1);
    req(48'h1000, 1'b0);
    check("t2_done", 48'(inj_done_o), 48'd1);
    for (int b = 0; b < 4; b++) rsp($sformatf("t2_beat_%0d", b), 3'd0, (b == 3), 3'd3);
    check("t2_beats", 48'(inj_beats_o), StatsEn ? 48'd4 : 48'd0);
    req(48'h1004, 1'b0);
    rsp("t2_untagged", 3'd2, 1'b1, 3'd2);
    rsp("t2_empty", 3'd1, 1'b1, 3'd1);

    // Unlimited budget.
    do_reset();
    cfg_code_i = 3'd5;
    cfg_en_i   = 1'b1;
    arm(16'd0);
    for (int i = 0; i < 10; i++) begin
      req(48'h1000 + 48'(i * 4), 1'b0);
      rsp($sformatf("t3_err_%0d", i), 3'd0, 1'b1, 3'd5);
    end
    check("t3_armed", 48'(inj_armed_o), 48'd1);
    check("t3_done", 48'(inj_done_o), 48'd0);
    check("t3_rem", 48'(inj_remaining_o), 48'd0);

    // Tag FIFO overflow freezes the channel into pass-through.
    do_reset();
    cfg_code_i = 3'd3;
    cfg_en_i   = 1'b1;
    arm(16'd0);
    for (int i = 0; i < 5; i++) begin
      req(48'h1000, 1'b0);
      check($sformatf("t4_ovf_%0d", i), 48'(tag_overflow_o), (i == 4) ? 48'd1 : 48'd0);
    end
    rsp("t4_pass_a", 3'd5, 1'b1, 3'd5);
    rsp("t4_pass_b", 3'd5, 1'b1, 3'd5);
    check("t4_ovf_sticky", 48'(tag_overflow_o), 48'd1);

    // Arm beats a concurrent request; disable keeps in-flight tags.
    do_reset();
    cfg_code_i = 3'd6;
    cfg_en_i   = 1'b1;
    arm(16'd3);
    req(48'h1000, 1'b1);
    check("t5_rem_arm", 48'(inj_remaining_o), 48'd3);
    check("t5_armed", 48'(inj_armed_o), 48'd1);
    rsp("t5_arm_untagged", 3'd0, 1'b1, 3'd0);
    req(48'h1000, 1'b0);
    req(48'h1004, 1'b0);
    check("t5_rem_two", 48'(inj_remaining_o), 48'd1);
    cfg_en_i = 1'b0;
    step();
    check("t5_idle_armed", 48'(inj_armed_o), 48'd0);
    check("t5_idle_done", 48'(inj_done_o), 48'd0);
    rsp("t5_inflight_a", 3'd0, 1'b1, 3'd6);
    rsp("t5_inflight_b", 3'd0, 1'b1, 3'd6);
    req(48'h1000, 1'b0);
    rsp("t5_disabled", 3'd0, 1'b1, 3'd0);

    // Asynchronous reset in the middle of a tagged burst.
    do_reset();
    cfg_code_i = 3'd3;
    cfg_en_i   = 1'b1;
    arm(16'd5);
    req(48'h1000, 1'b0);
    rsp("t6_beat0", 3'd0, 1'b0, 3'd3);
    check("t6_rem_pre", 48'(inj_remaining_o), 48'd4);
    rsp_hs_valid_i = 1'b1;
    rsp_err_i      = 3'd6;
    #2;
    rst_i = 1'b1;
    #1;
    check("t6_async_armed", 48'(inj_armed_o), 48'd0);
    check("t6_async_rem", 48'(inj_remaining_o), 48'd0);
    check("t6_async_beats", 48'(inj_beats_o), 48'd0);
    check("t6_async_err", 48'(rsp_err_o), 48'd6);
    step();
    rst_i = 1'b0;
    rsp("t6_post_reset", 3'd6, 1'b1, 3'd6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
